grid_ccff_shadow_chain: RTL and testbench

GRID_CCFF_SHADOW_CHAIN -- requirements
Module: grid_ccff_shadow_chain

---
 rtl/grid_ccff_pkg.sv | 19 +
 rtl/ccff_chain_slice.sv | 49 ++++
 rtl/grid_ccff_shadow_chain.sv | 117 +++++++++++
 tb/tb_grid_ccff_shadow_chain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_ccff_pkg.sv
// Shared types and defaults for the configuration-chain shadow register block.
// Holds the fill-state enum, default geometry and the counter-width helper.
package grid_ccff_pkg;

  localparam int unsigned DEF_NUM_CHAINS = 1;
  localparam int unsigned DEF_CHAIN_LEN  = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } ccff_state_t;

  // Bits needed to count 0..len inclusive.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_slice.sv
// One serial configuration chain with its shadow register and scan-transparent output.
// Optional GRID_CCFF_PARITY_EN exposes the XOR of the shift content.
module ccff_chain_slice
  import grid_ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 test_enable,
  input  logic                 ccff_head,
  input  logic                 shift_en,
  input  logic                 commit,
  output logic                 ccff_tail,
  output logic [CHAIN_LEN-1:0] cfg_out
`ifdef GRID_CCFF_PARITY_EN
  ,
  output logic                 parity
`endif
);

  logic [CHAIN_LEN-1:0] shift_q;
  logic [CHAIN_LEN-1:0] shadow_q;

  // Stage 0 takes the head bit; data moves towards the tail at CHAIN_LEN-1.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[CHAIN_LEN-2:0], ccff_head};
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shadow_q <= '0;
    end else if (commit) begin
      shadow_q <= shift_q;
    end
  end

  assign ccff_tail = shift_q[CHAIN_LEN-1];
  assign cfg_out   = test_enable ? shift_q : shadow_q;

`ifdef GRID_CCFF_PARITY_EN
  assign parity = ^shift_q;
`endif

endmodule

// File: rtl/grid_ccff_shadow_chain.sv
// Parallel configuration chains sharing one fill-state FSM and shift counter.
// Define GRID_CCFF_PARITY_EN to add per-chain parity checking on load.
module grid_ccff_shadow_chain
  import grid_ccff_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = DEF_NUM_CHAINS,
  parameter int unsigned CHAIN_LEN  = DEF_CHAIN_LEN
) (
  input  logic                            prog_clk,
  input  logic                            prog_reset,
  input  logic                            test_enable,
  input  logic [NUM_CHAINS-1:0]           ccff_head,
  input  logic                            shift_en,
  input  logic                            load,
`ifdef GRID_CCFF_PARITY_EN
  input  logic [NUM_CHAINS-1:0]           ccff_parity,
  output logic                            parity_err,
`endif
  output logic [NUM_CHAINS-1:0]           ccff_tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_out,
  output logic                            cfg_valid,
  output logic                            load_err,
  output logic [cnt_width(CHAIN_LEN)-1:0] bit_cnt
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN);

  ccff_state_t state;
  logic        load_eligible;
  logic        parity_ok;
  logic        commit;

`ifdef GRID_CCFF_PARITY_EN
  logic [NUM_CHAINS-1:0] chain_par;
  assign parity_ok = (chain_par == ccff_parity);
`else
  assign parity_ok = 1'b1;
`endif

  // Commit is decided from the registered state so the shadow captures on the same edge.
  assign load_eligible = load && !shift_en && (state == ST_FULL);
  assign commit        = load_eligible && parity_ok;

  genvar c;
  generate
    for (c = 0; c < NUM_CHAINS; c++) begin : g_chain
      ccff_chain_slice #(
        .CHAIN_LEN(CHAIN_LEN)
      ) u_slice (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .test_enable(test_enable),
        .ccff_head  (ccff_head[c]),
        .shift_en   (shift_en),
        .commit     (commit),
        .ccff_tail  (ccff_tail[c]),
        .cfg_out    (cfg_out[c*CHAIN_LEN +: CHAIN_LEN])
`ifdef GRID_CCFF_PARITY_EN
        ,
        .parity     (chain_par[c])
`endif
      );
    end
  endgenerate

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state     <= ST_EMPTY;
      bit_cnt   <= '0;
      cfg_valid <= 1'b0;
      load_err  <= 1'b0;
`ifdef GRID_CCFF_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      load_err <= 1'b0;
`ifdef GRID_CCFF_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (commit) begin
        state     <= ST_EMPTY;
        bit_cnt   <= '0;
        cfg_valid <= 1'b1;
      end else begin
        if (load) begin
          load_err <= 1'b1;
`ifdef GRID_CCFF_PARITY_EN
          parity_err <= load_eligible && !parity_ok;
`endif
        end
        if (shift_en) begin
          unique case (state)
            ST_EMPTY: begin
              state   <= ST_FILL;
              bit_cnt <= CW'(1);
            end
            ST_FILL: begin
              bit_cnt <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(CHAIN_LEN - 1)) begin
                state <= ST_FULL;
              end
            end
            ST_FULL: begin
              state   <= ST_FULL;
              bit_cnt <= CW'(CHAIN_LEN);
            end
            default: begin
              state   <= ST_EMPTY;
              bit_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_ccff_shadow_chain.sv
// Directed self-checking bench for grid_ccff_shadow_chain, NUM_CHAINS=2, CHAIN_LEN=8.
// Parity scenario is compiled in only when GRID_CCFF_PARITY_EN is defined.
module tb_grid_ccff_shadow_chain;

  logic        prog_clk;
  logic        prog_reset;
  logic        test_enable;
  logic [1:0]  ccff_head;
  logic        shift_en;
  logic        load;
  logic [1:0]  ccff_tail;
  logic [15:0] cfg_out;
  logic        cfg_valid;
  logic        load_err;
  logic [3:0]  bit_cnt;
`ifdef GRID_CCFF_PARITY_EN
  logic [1:0]  ccff_parity;
  logic        parity_err;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  grid_ccff_shadow_chain #(
    .NUM_CHAINS(2),
    .CHAIN_LEN (8)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .test_enable(test_enable),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .load       (load),
`ifdef GRID_CCFF_PARITY_EN
    .ccff_parity(ccff_parity),
    .parity_err (parity_err),
`endif
    .ccff_tail  (ccff_tail),
    .cfg_out    (cfg_out),
    .cfg_valid  (cfg_valid),
    .load_err   (load_err),
    .bit_cnt    (bit_cnt)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    prog_reset = 1'b1;
    #2;
    prog_reset = 1'b0;
    step();
  endtask

  // MSB-first: bit 7 of each byte is shifted in first and ends up at stage 7.
  task automatic shift_bytes(input logic [7:0] d0, input logic [7:0] d1);
    for (int i = 7; i >= 0; i--) begin
      ccff_head = {d1[i], d0[i]};
      shift_en  = 1'b1;
      step();
    end
    shift_en  = 1'b0;
    ccff_head = 2'b00;
  endtask

  task automatic shift_const(input logic [1:0] h, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ccff_head = h;
      shift_en  = 1'b1;
      step();
    end
    shift_en  = 1'b0;
    ccff_head = 2'b00;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    prog_reset  = 1'b1;
    test_enable = 1'b0;
    ccff_head   = 2'b00;
    shift_en    = 1'b0;
    load        = 1'b0;
`ifdef GRID_CCFF_PARITY_EN
    ccff_parity = 2'b00;
`endif
    #1;
    check_eq("rst_cfg_out", 32'(cfg_out), 32'h0);
    check_eq("rst_cfg_valid", 32'(cfg_valid), 32'h0);
    check_eq("rst_load_err", 32'(load_err), 32'h0);
    check_eq("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    check_eq("rst_tail", 32'(ccff_tail), 32'h0);
    step();
    step();
    prog_reset = 1'b0;
    step();

    // Load in EMPTY is rejected.
    pulse_load();
    check_eq("empty_load_err", 32'(load_err), 32'h1);
    check_eq("empty_cfg_valid", 32'(cfg_valid), 32'h0);

    // Basic fill and commit.
    shift_bytes(8'hA5, 8'h3C);
    check_eq("fill_bit_cnt", 32'(bit_cnt), 32'h8);
    check_eq("fill_tail", 32'(ccff_tail), 32'h1);
    check_eq("fill_cfg_out_shadow", 32'(cfg_out), 32'h0);
    pulse_load();
    check_eq("commit_cfg_out", 32'(cfg_out), 32'h3CA5);
    check_eq("commit_cfg_valid", 32'(cfg_valid), 32'h1);
    check_eq("commit_bit_cnt", 32'(bit_cnt), 32'h0);
    check_eq("commit_load_err", 32'(load_err), 32'h0);
    test_enable = 1'b1;
    #1;
    check_eq("commit_shift_kept", 32'(cfg_out), 32'h3CA5);
    test_enable = 1'b0;

    // Load with concurrent shift in FULL: rejected, shift proceeds, shadow kept.
    shift_bytes(8'h0F, 8'hF0);
    check_eq("full_bit_cnt", 32'(bit_cnt), 32'h8);
    ccff_head = 2'b00;
    shift_en  = 1'b1;
    load      = 1'b1;
    step();
    shift_en  = 1'b0;
    load      = 1'b0;
    check_eq("shiftload_err", 32'(load_err), 32'h1);
    check_eq("shiftload_bit_cnt", 32'(bit_cnt), 32'h8);
    check_eq("shiftload_shadow", 32'(cfg_out), 32'h3CA5);
    test_enable = 1'b1;
    #1;
    check_eq("shiftload_shift", 32'(cfg_out), 32'hE01E);
    test_enable = 1'b0;
    step();
    check_eq("shiftload_err_1cyc", 32'(load_err), 32'h0);
    pulse_load();
    check_eq("reload_cfg_out", 32'(cfg_out), 32'hE01E);
    check_eq("reload_load_err", 32'(load_err), 32'h0);

    // Partial fill then load.
    pulse_reset();
    shift_const(2'b01, 5);
    pulse_load();
    check_eq("partial_load_err", 32'(load_err), 32'h1);
    check_eq("partial_cfg_valid", 32'(cfg_valid), 32'h0);
    check_eq("partial_bit_cnt", 32'(bit_cnt), 32'h5);
    check_eq("partial_cfg_out", 32'(cfg_out), 32'h0);
    step();
    check_eq("partial_err_1cyc", 32'(load_err), 32'h0);

    // Scan transparency.
    pulse_reset();
    shift_const(2'b11, 3);
    test_enable = 1'b1;
    #1;
    check_eq("te1_cfg_out", 32'(cfg_out), 32'h0707);
    check_eq("te1_bit_cnt", 32'(bit_cnt), 32'h3);
    test_enable = 1'b0;
    #1;
    check_eq("te0_cfg_out", 32'(cfg_out), 32'h0);

    // Saturation: data keeps moving past CHAIN_LEN.
    pulse_reset();
    shift_const(2'b00, 8);
    shift_const(2'b11, 2);
    check_eq("sat_bit_cnt", 32'(bit_cnt), 32'h8);
    test_enable = 1'b1;
    #1;
    check_eq("sat_cfg_out", 32'(cfg_out), 32'h0303);
    test_enable = 1'b0;

    // Asynchronous reset mid-fill after a commit.
    pulse_reset();
    shift_bytes(8'hA5, 8'h3C);
    pulse_load();
    shift_const(2'b11, 6);
    test_enable = 1'b1;
    #1;
    check_eq("pre_arst_cfg_out", 32'(cfg_out), 32'h3F7F);
    check_eq("pre_arst_bit_cnt", 32'(bit_cnt), 32'h6);
    #1;
    prog_reset = 1'b1;
    #1;
    check_eq("arst_cfg_out", 32'(cfg_out), 32'h0);
    check_eq("arst_cfg_valid", 32'(cfg_valid), 32'h0);
    check_eq("arst_bit_cnt", 32'(bit_cnt), 32'h0);
    check_eq("arst_tail", 32'(ccff_tail), 32'h0);
    #1;
    prog_reset  = 1'b0;
    test_enable = 1'b0;
    pulse_load();
    check_eq("arst_empty_load_err", 32'(load_err), 32'h1);
    shift_const(2'b01, 1);
    check_eq("arst_first_shift_cnt", 32'(bit_cnt), 32'h1);

`ifdef GRID_CCFF_PARITY_EN
    // Parity mismatch on chain 0 blocks an otherwise valid load.
    pulse_reset();
    shift_bytes(8'hA5, 8'h3C);
    ccff_parity = 2'b01;
    pulse_load();
    check_eq("par_parity_err", 32'(parity_err), 32'h1);
    check_eq("par_load_err", 32'(load_err), 32'h1);
    check_eq("par_cfg_valid", 32'(cfg_valid), 32'h0);
    check_eq("par_cfg_out", 32'(cfg_out), 32'h0);
    check_eq("par_bit_cnt", 32'(bit_cnt), 32'h8);
    ccff_parity = 2'b00;
    pulse_load();
    check_eq("par_ok_parity_err", 32'(parity_err), 32'h0);
    check_eq("par_ok_cfg_out", 32'(cfg_out), 32'h3CA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
